// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the five-stage pipeline.
// Resolves stall requests by priority (MEM > EX > ID > IF) and produces the
// per-stage hold vector, if_id/id_ex bubbles, the branch flush and the PC
// redirect.
// When a taken branch arrives while an instruction fetch is still in flight,
// the redirect is held back in REDIR_WAIT until the stale fetch has returned
// and been discarded.
// Optional feature macro: PIPE_CTRL_PERF_EN adds stall-cycle and flush
// performance counters.
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall_req,
    input  logic        id_stall_req,
    input  logic        ex_stall_req,
    input  logic        mem_stall_req,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [4:0]  stall,
    output logic        if_id_bubble,
    output logic        id_ex_bubble,
    output logic        branch_interception,
    output logic        if_discard,
    output logic        pc_redirect,
    output logic [31:0] pc_target
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
`endif
);

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] target_q;
    logic [31:0] target_d;
    logic        branchAccept;

    // State and deferred-target registers; reset returns to RUN with no pending target
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Next-state and all control outputs; everything is forced low while reset is held
    always_comb begin
        state_d             = state_q;
        target_d            = target_q;
        branchAccept        = 1'b0;
        stall               = 5'b00000;
        if_id_bubble        = 1'b0;
        id_ex_bubble        = 1'b0;
        branch_interception = 1'b0;
        if_discard          = 1'b0;
        pc_redirect         = 1'b0;
        pc_target           = 32'd0;

        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    branchAccept = ex_branch_taken && !mem_stall_req && !ex_stall_req;
                    if (branchAccept) begin
                        branch_interception = 1'b1;
                        if (!if_stall_req) begin
                            pc_redirect = 1'b1;
                            pc_target   = ex_branch_target;
                        end else begin
                            target_d = ex_branch_target;
                            state_d  = REDIR_WAIT;
                        end
                    end else if (mem_stall_req) begin
                        stall = 5'b01111;
                    end else if (ex_stall_req) begin
                        stall = 5'b00111;
                    end else if (id_stall_req) begin
                        stall        = 5'b00011;
                        id_ex_bubble = 1'b1;
                    end else if (if_stall_req) begin
                        stall        = 5'b00001;
                        if_id_bubble = 1'b1;
                    end
                end
                REDIR_WAIT: begin
                    if_discard          = 1'b1;
                    branch_interception = 1'b1;
                    stall[0]            = 1'b1;
                    stall[3]            = mem_stall_req;
                    if (!if_stall_req) begin
                        pc_redirect = 1'b1;
                        pc_target   = target_q;
                        state_d     = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perfStall_q;
    logic [31:0] perfFlush_q;

    // Performance counters: cycles with any hold bit set, and accepted branches
    always_ff @(posedge clk) begin
        if (rst) begin
            perfStall_q <= 32'd0;
            perfFlush_q <= 32'd0;
        end else begin
            if (stall != 5'b00000) perfStall_q <= perfStall_q + 32'd1;
            if (branchAccept)      perfFlush_q <= perfFlush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perfStall_q;
    assign perf_flush_count  = perfFlush_q;
`endif

endmodule
